// File: rtl/bilbo_reg_n.sv
// BILBO register: parallel load, scan shift, PRPG and MISR modes, with a
// counted PRPG/MISR session controller and signature compare.
`timescale 1ns/1ps
module bilbo_reg_n #(
  parameter int unsigned           WIDTH = 8,
  parameter logic [WIDTH-1:0]      POLY  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0]      SEED  = WIDTH'(8'h01),
  parameter int unsigned           CW    = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  input  logic             scan_in,
  input  logic             start,
  input  logic [CW-1:0]    cycles,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] q,
  output logic             scan_out,
  output logic             busy,
  output logic             done,
  output logic             match
);

  localparam logic [1:0] M_NORMAL = 2'b00;
  localparam logic [1:0] M_SCAN   = 2'b01;
  localparam logic [1:0] M_PRPG   = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       sess_mode_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic             fb;
  logic [WIDTH-1:0] lfsr_next;
  logic             mode_chg;

  assign fb        = ^(q_q & POLY);
  assign lfsr_next = {q_q[WIDTH-2:0], fb};
  // Leaving the session's mode aborts a RUN or releases DONE.
  assign mode_chg  = (mode != sess_mode_q);

  always_comb begin
    q_d = q_q;
    if (state_q == RUN) begin
      if (!mode_chg) begin
        if (sess_mode_q == M_PRPG) q_d = (q_q == '0) ? SEED : lfsr_next;
        else                       q_d = lfsr_next ^ data;
      end
    end else if (!mode[1] && en) begin
      if (mode == M_NORMAL)    q_d = data;
      else if (mode == M_SCAN) q_d = {q_q[WIDTH-2:0], scan_in};
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sess_mode_q <= M_NORMAL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE && mode_chg) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else if (start && mode[1]) begin
            sess_mode_q <= mode;
            if (cycles != '0) begin
              state_q <= RUN;
              cnt_q   <= cycles;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (mode_chg) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q        = q_q;
  assign scan_out = q_q[WIDTH-1];
  assign busy     = busy_q;
  assign done     = done_q;
  assign match    = done_q && (q_q == golden);

endmodule

// File: tb/tb_bilbo_reg_n.sv
// Directed self-checking bench for bilbo_reg_n with hand-computed expectations.
`timescale 1ns/1ps
module tb_bilbo_reg_n;

  logic        clock = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        en;
  logic [7:0]  data;
  logic        scan_in;
  logic        start;
  logic [15:0] cycles;
  logic [7:0]  golden;
  logic [7:0]  q;
  logic        scan_out, busy, done, match;

  int checks   = 0;
  int failures = 0;

  bilbo_reg_n dut (
    .clock(clock), .rst(rst), .mode(mode), .en(en), .data(data),
    .scan_in(scan_in), .start(start), .cycles(cycles), .golden(golden),
    .q(q), .scan_out(scan_out), .busy(busy), .done(done), .match(match)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [7:0] prpg_exp [5];
  logic [7:0] scan_bits;
  bit         saw_done;

  initial begin
    rst = 1'b1; mode = 2'b00; en = 1'b0; data = '0; scan_in = 1'b0;
    start = 1'b0; cycles = '0; golden = '0;
    #3;
    chk("rst_q", q, 8'h00);
    chk("rst_scan_out", scan_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_match", match, 1'b0);
    tick();
    rst = 1'b0;

    // NORMAL hold / load / start ignored
    data = 8'h5A;
    repeat (3) tick();
    chk("normal_hold", q, 8'h00);
    en = 1'b1;
    tick();
    chk("normal_load", q, 8'h5A);
    en = 1'b0; start = 1'b1; cycles = 16'd4;
    tick();
    start = 1'b0;
    tick();
    chk("normal_start_busy", busy, 1'b0);
    chk("normal_start_done", done, 1'b0);
    chk("normal_start_q", q, 8'h5A);

    // SCAN shift 1,0,1,0,...
    mode = 2'b01; en = 1'b1;
    scan_bits = 8'b1010_1010;
    for (int i = 7; i >= 0; i--) begin
      scan_in = scan_bits[i];
      tick();
    end
    en = 1'b0;
    chk("scan_q", q, 8'hAA);
    chk("scan_out", scan_out, 1'b1);

    // PRPG session of 5 steps from zero
    do_reset();
    prpg_exp[0] = 8'h01; prpg_exp[1] = 8'h02; prpg_exp[2] = 8'h04;
    prpg_exp[3] = 8'h08; prpg_exp[4] = 8'h11;
    mode = 2'b10; cycles = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("prpg_start_busy", busy, 1'b1);
    chk("prpg_start_q", q, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("prpg_step%0d", i + 1), q, prpg_exp[i]);
      chk($sformatf("prpg_busy%0d", i + 1), busy, (i < 4) ? 1'b1 : 1'b0);
    end
    chk("prpg_done", done, 1'b1);
    tick();
    chk("prpg_done_hold_q", q, 8'h11);
    chk("prpg_done_hold", done, 1'b1);

    // Leave DONE, then zero-length PRPG session
    mode = 2'b00;
    tick();
    chk("done_exit", done, 1'b0);
    mode = 2'b10; cycles = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_q", q, 8'h11);

    // MISR signature
    do_reset();
    mode = 2'b11; data = 8'hFF; cycles = 16'd2; golden = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    chk("misr_busy", busy, 1'b1);
    tick();
    chk("misr_step1", q, 8'hFF);
    chk("misr_match_running", match, 1'b0);
    tick();
    chk("misr_step2", q, 8'h01);
    chk("misr_done", done, 1'b1);
    chk("misr_match", match, 1'b1);
    golden = 8'h02;
    #1;
    chk("misr_mismatch", match, 1'b0);

    // Abort by mode change at step 3
    do_reset();
    mode = 2'b10; cycles = 16'd10; start = 1'b1; en = 1'b0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("abort_step3", q, 8'h04);
    mode = 2'b00;
    tick();
    chk("abort_q", q, 8'h04);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (12) tick();
    chk("abort_done_later", done, 1'b0);

    // Abort by reset at step 3
    mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("rrun_step3", q, 8'h23);
    chk("rrun_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rrun_q", q, 8'h00);
    chk("rrun_busy0", busy, 1'b0);
    chk("rrun_done0", done, 1'b0);
    chk("rrun_scan_out", scan_out, 1'b0);
    chk("rrun_match", match, 1'b0);
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("rrun_no_done", saw_done, 1'b0);
    chk("rrun_idle_q", q, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bilbo_reg_n.md
BILBO_REG_N -- requirements
Module: bilbo_reg_n

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8: register width, legal range 2..32.
REQ-002 The block SHALL have parameter POLY, default 8'hB8: LFSR feedback tap mask, WIDTH bits.
REQ-003 The block SHALL have parameter SEED, default 8'h01: nonzero reload value for PRPG lockup escape.
REQ-004 The block SHALL have parameter CW, default 16: session cycle-counter width.

Interface
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 mode  in  2  00 NORMAL, 01 SCAN, 10 PRPG, 11 MISR.
REQ-008 en  in  1  update enable for NORMAL and SCAN modes.
REQ-009 data  in  WIDTH  functional parallel data; MISR compaction input.
REQ-010 scan_in  in  1  serial scan input.
REQ-011 start  in  1  one-cycle pulse that begins a PRPG/MISR session.
REQ-012 cycles  in  CW  session length; sampled only on an accepted start.
REQ-013 golden  in  WIDTH  expected signature for comparison.
REQ-014 q  out  WIDTH  register contents.
REQ-015 scan_out  out  1  q[WIDTH-1], combinational from the register.
REQ-016 busy  out  1  high in state RUN.
REQ-017 done  out  1  high in state DONE.
REQ-018 match  out  1  (q == golden) while done, else 0.

Function
REQ-019 fb SHALL equal the XOR-reduction of (q & POLY); next = {q[WIDTH-2:0], fb}.
REQ-020 NORMAL with en=1: q <= data; en=0: hold.
REQ-021 SCAN with en=1: q <= {q[WIDTH-2:0], scan_in}; en=0: hold.
REQ-022 PRPG step: q <= next; if q == 0, q <= SEED instead.
REQ-023 MISR step: q <= next ^ data; zero q is not special-cased.
REQ-024 In PRPG/MISR, q SHALL step only in state RUN; en is ignored.
REQ-025 Session FSM states: IDLE, RUN, DONE.
REQ-026 IDLE -> RUN on start=1 with mode[1]=1 and cycles != 0; counter loads cycles.
REQ-027 IDLE -> DONE on start=1 with mode[1]=1 and cycles == 0; q is unchanged.
REQ-028 start with mode[1]=0 SHALL be ignored.
REQ-029 RUN: one step per cycle and the counter decrements; the step taken with counter == 1 moves to DONE. Exactly cycles steps occur, so done rises cycles+1 cycles after start.
REQ-030 start during RUN SHALL be ignored.
REQ-031 A mode change during RUN SHALL abort to IDLE with no step that cycle; done stays 0.
REQ-032 DONE: q holds and done stays 1 until a start (restarts per REQ-026/027) or a mode change (-> IDLE).
REQ-033 In DONE, match SHALL track golden combinationally.

Reset
REQ-034 rst=1 SHALL asynchronously force q=0, counter=0, state IDLE.
REQ-035 During and after reset, outputs SHALL read scan_out=0, busy=0, done=0, match=0.
REQ-036 Reset during RUN SHALL abandon the session; no done pulse follows.

Verification
REQ-037 SCAN, en=1, shift 1,0,1,0,1,0,1,0 (first bit first) -> q=8'hAA, scan_out=1.
REQ-038 After reset, PRPG with start and cycles=5 -> q sequence 00,01,02,04,08,11; done=1 on the cycle after the fifth step.
REQ-039 After reset, MISR with data=8'hFF, cycles=2, golden=8'h01 -> q=FF then 01; done=1, match=1; golden=8'h02 -> match=0.
REQ-040 PRPG with start and cycles=0 -> DONE next cycle, q unchanged, busy never 1.
REQ-041 RUN with cycles=10; set mode to NORMAL at step 3 -> IDLE, q holds step-3 value, done=0. Repeat, asserting rst at step 3 -> all outputs 0 immediately.
REQ-042 NORMAL, en=0, data=8'h5A for 3 cycles -> q unchanged; en=1 -> q=8'h5A next edge; start pulse -> ignored.
